// File: rtl/instr_mem_pkg.sv
// Shared types and constants for the boot-ROM read-port arbiter.
// The ROM window is 4 KiB of little-endian 32-bit words starting at the MIPS reset vector.
package instr_mem_pkg;

    localparam int          A_WIDTH   = 32;
    localparam int          D_WIDTH   = 32;
    localparam logic [31:0] ROM_BASE  = 32'hBFC0_0000;
    localparam int          ROM_BYTES = 4096;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_LD = 1'b1
    } port_e;

    typedef struct packed {
        logic               valid;
        logic [D_WIDTH-1:0] data;
        logic               err;
    } resp_t;

endpackage

// File: rtl/instr_mem_arbiter_if.sv
// Request/response channels of the fetch and load requesters plus the ROM read port.
// The master modport is the core/ROM side; the slave modport is the arbiter.
interface instr_mem_arbiter_if #(
    parameter int A_WIDTH = instr_mem_pkg::A_WIDTH,
    parameter int D_WIDTH = instr_mem_pkg::D_WIDTH
);
    logic               if_req_valid;
    logic               if_req_ready;
    logic [A_WIDTH-1:0] if_req_addr;
    logic               if_resp_valid;
    logic               if_resp_ready;
    logic [D_WIDTH-1:0] if_resp_data;
    logic               if_resp_err;
    logic               if_flush;

    logic               ld_req_valid;
    logic               ld_req_ready;
    logic [A_WIDTH-1:0] ld_req_addr;
    logic               ld_resp_valid;
    logic               ld_resp_ready;
    logic [D_WIDTH-1:0] ld_resp_data;
    logic               ld_resp_err;

    logic [A_WIDTH-1:0] mem_addr;
    logic [D_WIDTH-1:0] mem_rdata;

    modport master (
        output if_req_valid, if_req_addr, if_resp_ready, if_flush,
        output ld_req_valid, ld_req_addr, ld_resp_ready,
        output mem_rdata,
        input  if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
        input  ld_req_ready, ld_resp_valid, ld_resp_data, ld_resp_err,
        input  mem_addr
    );

    modport slave (
        input  if_req_valid, if_req_addr, if_resp_ready, if_flush,
        input  ld_req_valid, ld_req_addr, ld_resp_ready,
        input  mem_rdata,
        output if_req_ready, if_resp_valid, if_resp_data, if_resp_err,
        output ld_req_ready, ld_resp_valid, ld_resp_data, ld_resp_err,
        output mem_addr
    );
endinterface

// File: rtl/instr_mem_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie the port not granted last wins.
// last_grant only moves when the caller signals that the grant was accepted.
module rr_arbiter2
    import instr_mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);
    port_e last_grant_r;

    // Grant selection: bit 0 is IF, bit 1 is LD.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11: begin
                if (last_grant_r == PORT_LD) begin
                    grant = 2'b01;
                end else begin
                    grant = 2'b10;
                end
            end
            default: grant = 2'b00;
        endcase
    end

    // Remember the last accepted winner; reset favours IF on the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= PORT_LD;
        end else if (update) begin
            last_grant_r <= grant[1] ? PORT_LD : PORT_IF;
        end
    end
endmodule

// File: rtl/instr_mem_arbiter.sv
// Shares the boot ROM's combinational read port between fetch (IF) and load (LD)
// requesters, with one registered response buffer per requester.
module instr_mem_arbiter
    import instr_mem_pkg::*;
#(
    parameter int               A_WIDTH   = instr_mem_pkg::A_WIDTH,
    parameter int               D_WIDTH   = instr_mem_pkg::D_WIDTH,
    parameter logic [A_WIDTH-1:0] ROM_BASE  = instr_mem_pkg::ROM_BASE,
    parameter int               ROM_BYTES = instr_mem_pkg::ROM_BYTES
)(
    input  logic               clk,
    input  logic               rst,
    instr_mem_arbiter_if.slave bus
);
    logic [1:0]         req_s;
    logic [1:0]         grant_s;
    logic               upd_s;
    logic               if_free_s;
    logic               ld_free_s;
    logic               if_acc_s;
    logic               ld_acc_s;
    logic [A_WIDTH:0]   addr_ext_s;
    logic [A_WIDTH:0]   win_lo_s;
    logic [A_WIDTH:0]   win_hi_s;
    logic               acc_err_s;
    logic [D_WIDTH-1:0] acc_data_s;
    resp_t              if_buf_r;
    resp_t              ld_buf_r;

    // A buffer can take a new word if empty or being drained this cycle; nothing is granted in reset.
    assign if_free_s = !if_buf_r.valid || bus.if_resp_ready;
    assign ld_free_s = !ld_buf_r.valid || bus.ld_resp_ready;
    assign req_s[0]  = bus.if_req_valid && if_free_s && !bus.if_flush && !rst;
    assign req_s[1]  = bus.ld_req_valid && ld_free_s && !rst;
    assign upd_s     = |grant_s;
    assign if_acc_s  = grant_s[0];
    assign ld_acc_s  = grant_s[1];

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_s),
        .update (upd_s),
        .grant  (grant_s)
    );

    assign bus.if_req_ready = if_acc_s;
    assign bus.ld_req_ready = ld_acc_s;
    assign bus.mem_addr     = ld_acc_s ? bus.ld_req_addr : bus.if_req_addr;

    // Window check one bit wider than the address so the upper bound cannot wrap.
    always_comb begin
        addr_ext_s = {1'b0, bus.mem_addr};
        win_lo_s   = {1'b0, ROM_BASE};
        win_hi_s   = win_lo_s + (A_WIDTH+1)'(ROM_BYTES - 4);
        acc_err_s  = (addr_ext_s < win_lo_s) || (addr_ext_s > win_hi_s) ||
                     (bus.mem_addr[1:0] != 2'b00);
        if (acc_err_s) begin
            acc_data_s = '0;
        end else begin
            acc_data_s = bus.mem_rdata;
        end
    end

    // IF response buffer; a branch redirect drops it even if it is being consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_buf_r <= '0;
        end else if (bus.if_flush) begin
            if_buf_r.valid <= 1'b0;
        end else if (if_acc_s) begin
            if_buf_r <= {1'b1, acc_data_s, acc_err_s};
        end else if (bus.if_resp_ready) begin
            if_buf_r.valid <= 1'b0;
        end
    end

    // LD response buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_buf_r <= '0;
        end else if (ld_acc_s) begin
            ld_buf_r <= {1'b1, acc_data_s, acc_err_s};
        end else if (bus.ld_resp_ready) begin
            ld_buf_r.valid <= 1'b0;
        end
    end

    assign bus.if_resp_valid = if_buf_r.valid;
    assign bus.if_resp_data  = if_buf_r.data;
    assign bus.if_resp_err   = if_buf_r.err;
    assign bus.ld_resp_valid = ld_buf_r.valid;
    assign bus.ld_resp_data  = ld_buf_r.data;
    assign bus.ld_resp_err   = ld_buf_r.err;
endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed bench for instr_mem_arbiter: a ROM model drives mem_rdata and a per-port
// scoreboard queues expected {err,data} on every accept and checks it on every consume.
module tb_instr_mem_arbiter;
    localparam logic [31:0] BASE = 32'hBFC0_0000;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    logic [7:0]  rom [4096];
    logic [32:0] off_s;
    logic [32:0] q_if [$];
    logic [32:0] q_ld [$];

    instr_mem_arbiter_if bus ();

    instr_mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM model: garbage outside the array so error zeroing is visible.
    always_comb begin
        off_s = {1'b0, bus.mem_addr} - {1'b0, BASE};
        if (({1'b0, bus.mem_addr} >= {1'b0, BASE}) && (off_s <= 33'd4092)) begin
            bus.mem_rdata = {rom[int'(off_s[11:0]) + 3], rom[int'(off_s[11:0]) + 2],
                             rom[int'(off_s[11:0]) + 1], rom[int'(off_s[11:0])]};
        end else begin
            bus.mem_rdata = 32'hDEAD_BEEF;
        end
    end

    function automatic logic [32:0] exp_of(input logic [31:0] a);
        logic [32:0] ea;
        logic        err;
        int          o;
        ea  = {1'b0, a};
        err = (ea < {1'b0, BASE}) || (ea > ({1'b0, BASE} + 33'd4092)) || (a[1:0] != 2'b00);
        if (err) begin
            return {1'b1, 32'h0000_0000};
        end
        o = int'(a[11:0]);
        return {1'b0, rom[o + 3], rom[o + 2], rom[o + 1], rom[o]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_check();
        logic [32:0] e;
        if (rst) begin
            q_if.delete();
            q_ld.delete();
        end else begin
            if (bus.if_flush) begin
                if (bus.if_resp_valid && q_if.size() > 0) begin
                    e = q_if.pop_front();
                end
            end else if (bus.if_resp_valid && bus.if_resp_ready) begin
                chk("if_resp_expected", 64'(q_if.size() != 0), 64'd1);
                if (q_if.size() > 0) begin
                    e = q_if.pop_front();
                    chk("if_resp", 64'({bus.if_resp_err, bus.if_resp_data}), 64'(e));
                end
            end
            if (bus.ld_resp_valid && bus.ld_resp_ready) begin
                chk("ld_resp_expected", 64'(q_ld.size() != 0), 64'd1);
                if (q_ld.size() > 0) begin
                    e = q_ld.pop_front();
                    chk("ld_resp", 64'({bus.ld_resp_err, bus.ld_resp_data}), 64'(e));
                end
            end
            if (bus.if_req_valid && bus.if_req_ready) q_if.push_back(exp_of(bus.if_req_addr));
            if (bus.ld_req_valid && bus.ld_req_ready) q_ld.push_back(exp_of(bus.ld_req_addr));
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        sb_check();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] last_word;
        logic [32:0] held;
        logic [31:0] ld_addrs [3];
        logic        ld_errs  [3];
        n_cmp = 0;
        n_bad = 0;
        for (int i = 0; i < 4096; i++) rom[i] = 8'((i * 37 + 11) ^ (i >> 4));
        rom[0] = 8'h13; rom[1] = 8'h00; rom[2] = 8'h00; rom[3] = 8'h00;
        last_word = {rom[4095], rom[4094], rom[4093], rom[4092]};

        rst = 1'b1;
        bus.if_req_valid = 1'b0; bus.if_req_addr = BASE; bus.if_resp_ready = 1'b1; bus.if_flush = 1'b0;
        bus.ld_req_valid = 1'b0; bus.ld_req_addr = BASE; bus.ld_resp_ready = 1'b1;
        cycle();
        bus.if_req_valid = 1'b1;
        #1;
        chk("rst_if_req_ready", 64'(bus.if_req_ready), 64'd0);
        cycle();
        chk("rst_if_resp_valid", 64'(bus.if_resp_valid), 64'd0);
        chk("rst_ld_resp_valid", 64'(bus.ld_resp_valid), 64'd0);
        chk("rst_if_resp_data",  64'(bus.if_resp_data), 64'd0);
        chk("rst_ld_resp_err",   64'(bus.ld_resp_err), 64'd0);
        chk("rst_if_req_ready2", 64'(bus.if_req_ready), 64'd0);

        // First fetch at the reset vector, one-cycle latency.
        rst = 1'b0;
        bus.if_req_addr = BASE;
        #1;
        chk("first_if_ready", 64'(bus.if_req_ready), 64'd1);
        cycle();
        bus.if_req_valid = 1'b0;
        chk("first_if_valid", 64'(bus.if_resp_valid), 64'd1);
        chk("first_if_data",  64'(bus.if_resp_data), 64'h13);
        chk("first_if_err",   64'(bus.if_resp_err), 64'd0);
        chk("first_ld_idle",  64'(bus.ld_resp_valid), 64'd0);
        cycle();

        // Continuous contention alternates grants, IF first after reset.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus.if_req_valid = 1'b1; bus.if_req_addr = BASE + 32'(4 * i);
            bus.ld_req_valid = 1'b1; bus.ld_req_addr = BASE + 32'h100 + 32'(4 * i);
            #1;
            chk("alt_if_ready", 64'(bus.if_req_ready), 64'((i % 2) == 0));
            chk("alt_ld_ready", 64'(bus.ld_req_ready), 64'((i % 2) == 1));
            cycle();
        end
        bus.if_req_valid = 1'b0; bus.ld_req_valid = 1'b0;
        cycle();
        cycle();

        // Window boundaries on LD.
        ld_addrs[0] = 32'hBFC0_1000; ld_errs[0] = 1'b1;
        ld_addrs[1] = 32'hBFBF_FFFC; ld_errs[1] = 1'b1;
        ld_addrs[2] = 32'hBFC0_0FFC; ld_errs[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.ld_req_valid = 1'b1; bus.ld_req_addr = ld_addrs[i];
            cycle();
            chk("bnd_ld_valid", 64'(bus.ld_resp_valid), 64'd1);
            chk("bnd_ld_err",   64'(bus.ld_resp_err), 64'(ld_errs[i]));
            chk("bnd_ld_data",  64'(bus.ld_resp_data), ld_errs[i] ? 64'd0 : 64'(last_word));
        end
        bus.ld_req_valid = 1'b0;
        cycle();

        // Misaligned fetch then a normal one.
        bus.if_req_valid = 1'b1; bus.if_req_addr = BASE + 32'h2;
        cycle();
        chk("mis_if_err",  64'(bus.if_resp_err), 64'd1);
        chk("mis_if_data", 64'(bus.if_resp_data), 64'd0);
        bus.if_req_addr = BASE + 32'h4;
        #1;
        chk("mis_next_ready", 64'(bus.if_req_ready), 64'd1);
        cycle();
        chk("mis_next_err",  64'(bus.if_resp_err), 64'd0);
        chk("mis_next_data", 64'(bus.if_resp_data), 64'({rom[7], rom[6], rom[5], rom[4]}));
        bus.if_req_valid = 1'b0;
        cycle();

        // IF backpressure: held response stays stable, LD keeps flowing.
        bus.if_resp_ready = 1'b0;
        bus.if_req_valid = 1'b1; bus.if_req_addr = BASE + 32'h8;
        held = exp_of(BASE + 32'h8);
        cycle();
        bus.if_req_addr = BASE + 32'hC;
        for (int k = 0; k < 3; k++) begin
            bus.ld_req_valid = 1'b1; bus.ld_req_addr = BASE + 32'h200 + 32'(4 * k);
            #1;
            chk("bp_if_ready",   64'(bus.if_req_ready), 64'd0);
            chk("bp_ld_ready",   64'(bus.ld_req_ready), 64'd1);
            chk("bp_if_valid",   64'(bus.if_resp_valid), 64'd1);
            chk("bp_if_stable",  64'({bus.if_resp_err, bus.if_resp_data}), 64'(held));
            cycle();
        end
        bus.if_resp_ready = 1'b1;
        #1;
        chk("bp_release_if_ready", 64'(bus.if_req_ready), 64'd1);
        cycle();
        bus.if_req_valid = 1'b0; bus.ld_req_valid = 1'b0;
        cycle();
        cycle();

        // Flush with a pending IF response and a live IF request.
        bus.if_resp_ready = 1'b0;
        bus.if_req_valid = 1'b1; bus.if_req_addr = BASE + 32'h10;
        cycle();
        bus.if_flush = 1'b1; bus.if_req_addr = BASE + 32'h14;
        bus.ld_req_valid = 1'b1; bus.ld_req_addr = BASE + 32'h18;
        #1;
        chk("flush_if_ready", 64'(bus.if_req_ready), 64'd0);
        chk("flush_ld_ready", 64'(bus.ld_req_ready), 64'd1);
        cycle();
        bus.if_flush = 1'b0; bus.if_req_valid = 1'b0; bus.ld_req_valid = 1'b0;
        chk("flush_if_valid", 64'(bus.if_resp_valid), 64'd0);
        chk("flush_ld_valid", 64'(bus.ld_resp_valid), 64'd1);
        bus.if_resp_ready = 1'b1;
        cycle();

        // Reset with both buffers full drops everything.
        bus.if_resp_ready = 1'b0; bus.ld_resp_ready = 1'b0;
        bus.if_req_valid = 1'b1; bus.if_req_addr = BASE + 32'h20;
        bus.ld_req_valid = 1'b1; bus.ld_req_addr = BASE + 32'h24;
        cycle();
        cycle();
        chk("pre_rst_if_valid", 64'(bus.if_resp_valid), 64'd1);
        chk("pre_rst_ld_valid", 64'(bus.ld_resp_valid), 64'd1);
        bus.if_resp_ready = 1'b1; bus.ld_resp_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk("mid_rst_if_ready", 64'(bus.if_req_ready), 64'd0);
        chk("mid_rst_ld_ready", 64'(bus.ld_req_ready), 64'd0);
        cycle();
        chk("mid_rst_if_valid", 64'(bus.if_resp_valid), 64'd0);
        chk("mid_rst_ld_valid", 64'(bus.ld_resp_valid), 64'd0);
        rst = 1'b0; bus.if_req_valid = 1'b0; bus.ld_req_valid = 1'b0;
        cycle();
        chk("post_rst_if_valid", 64'(bus.if_resp_valid), 64'd0);
        chk("post_rst_ld_valid", 64'(bus.ld_resp_valid), 64'd0);
        chk("q_if_drained", 64'(q_if.size()), 64'd0);
        chk("q_ld_drained", 64'(q_ld.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/instr_mem_arbiter.md
# instr_mem_arbiter

Shares the single combinational read port of the boot instruction ROM (byte-addressed, 4 KiB at 0xBFC00000, little-endian 32-bit words) between two requesters: the fetch stage (IF) and the load unit reading ROM-resident constants (LD). Each requester gets a valid/ready request channel and a registered response channel. Arbitration is round-robin. Out-of-window or misaligned addresses return an error response. The block sits between the core's fetch/memory stages and the ROM.

## Interface
- A_WIDTH, 32, address width
- D_WIDTH, 32, response word width (four ROM bytes)
- ROM_BASE, 32'hBFC00000, first byte address of ROM window
- ROM_BYTES, 4096, ROM window size in bytes

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req_valid / ld_req_valid  in  1  request present
- if_req_ready / ld_req_ready  out  1  request accepted this cycle when valid&ready
- if_req_addr / ld_req_addr  in  A_WIDTH  byte address of word
- if_resp_valid / ld_resp_valid  out  1  response held in buffer
- if_resp_ready / ld_resp_ready  in  1  requester consumes response
- if_resp_data / ld_resp_data  out  D_WIDTH  word {B[a+3],B[a+2],B[a+1],B[a]}
- if_resp_err / ld_resp_err  out  1  address out of window or addr[1:0]≠0
- if_flush  in  1  discard IF response/request (branch redirect)
- mem_addr  out  A_WIDTH  address to ROM
- mem_rdata  in  D_WIDTH  combinational ROM word for mem_addr

## Operation
- One response buffer per port (valid, data, err). Buffer "free" for port P = !P_resp_valid || P_resp_ready.
- Eligible(P) = P_req_valid && buffer free(P); IF additionally requires !if_flush.
- Round-robin: if both eligible, grant the port not granted last; else grant the sole eligible port; else no grant. last_grant updates only on an accepted request.
- P_req_ready = grant==P (combinational; may depend on P_req_valid and P_resp_ready).
- mem_addr = granted port's address; when no grant, mem_addr = if_req_addr.
- Error check on accept: err = (addr < ROM_BASE) || (addr > ROM_BASE+ROM_BYTES-4) || addr[1:0]≠0. On err, data captured as 0; ROM value not used.
- On accept: buffer ← {1, mem_rdata or 0, err}. On consume without new accept: valid ← 0. Accept and consume same cycle: buffer overwritten, valid stays 1.
- if_flush: IF buffer valid ← 0 next cycle; no IF grant that cycle; LD unaffected. Flush wins over simultaneous consume.
- Address comparison done in A_WIDTH+1 bits so ROM_BASE+ROM_BYTES-4 never wraps.

## Timing
- Reset (rst=1 at edge): all resp_valid=0, resp_data=0, resp_err=0, last_grant=LD (so IF wins the first tie). req_ready is 0 during reset cycles.
- Latency: request accepted at edge N → resp_valid=1 after edge N (visible cycle N+1).
- Throughput: 1 accept per port per cycle while resp_ready held high and no contention; under continuous contention each port gets every other cycle.
- Responses held stable (data, err) while valid && !ready.
- Reset mid-operation drops all buffered responses; no response is issued for a request accepted in the reset cycle.

## Structure
- Package instr_mem_pkg: ROM_BASE, ROM_BYTES, port enum typedef port_e {PORT_IF, PORT_LD}, resp_t struct {valid, data, err}.
- Sub-module rr_arbiter2: two request bits in, one-hot grant out, last_grant register, update-enable input.
- Top instantiates rr_arbiter2, two response buffers, address checker, mem_addr mux.

## Test plan
- Reset then IF reads 0xBFC00000 with ROM bytes 13,00,00,00 → cycle after accept if_resp_valid=1, data=0x00000013, err=0; ld side idle.
- Both ports request every cycle, resp_ready=1 → grants alternate IF, LD, IF, LD…; first grant IF.
- LD reads 0xBFC01000 and 0xBFBFFFFC → ld_resp_err=1, data=0; LD reads 0xBFC00FFC → err=0, data = last ROM word.
- IF reads 0xBFC00002 → err=1; next request 0xBFC00004 accepted normally.
- Hold if_resp_ready=0 for 3 cycles with if_req_valid=1 → if_req_ready=0, data stable; LD still served each cycle; on ready=1, IF accepted same cycle.
- Assert if_flush with IF response pending and IF request valid → if_resp_valid=0 next cycle, no IF accept that cycle; assert rst mid-stream → all resp_valid=0 after edge.
